// File: rtl/traffic_light_seq.sv
// Round-robin multi-approach traffic-light sequencer with pedestrian shortening,
// emergency stop and a two-digit seven-segment countdown of the seconds remaining.
module traffic_light_seq #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int N_DIR     = 2,
   parameter int CW        = 8,
   parameter int T_ARROW   = 3,
   parameter int T_GREEN   = 10,
   parameter int T_YELLOW  = 3,
   parameter int T_ALLRED  = 2,
   parameter int T_PED_MIN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             ped_req,
   input  logic             emergency,
   output logic [N_DIR-1:0] arrow,
   output logic [N_DIR-1:0] green,
   output logic [N_DIR-1:0] yellow,
   output logic [N_DIR-1:0] red,
   output logic [2:0]       active_dir,
   output logic [CW-1:0]    remaining,
   output logic [5:0]       states,
   output logic [6:0]       hex1,
   output logic [6:0]       hex0
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ARROW, S_GREEN, S_YELLOW, S_ALLRED, S_STOP
   } state_t;

   state_t          r_state;
   logic [2:0]      r_dir;
   logic [CW-1:0]   r_rem;
   logic [PW-1:0]   r_pre;
   logic            r_ped;

   logic            w_tick;
   logic            w_ped;
   logic            w_shorten;
   state_t          w_first_state;
   logic [CW-1:0]   w_first_rem;

   // An ARROW time of zero removes the ARROW phase from every cycle.
   assign w_first_state = (T_ARROW == 0) ? S_GREEN : S_ARROW;
   assign w_first_rem   = (T_ARROW == 0) ? CW'(T_GREEN) : CW'(T_ARROW);
   assign w_tick        = (r_pre == PW'(TICK_DIV - 1));
   assign w_ped         = r_ped | ped_req;
   assign w_shorten     = (r_state == S_GREEN) && w_ped && (r_rem > CW'(T_PED_MIN));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_dir   <= '0;
         r_rem   <= '0;
         r_pre   <= '0;
         r_ped   <= 1'b0;
      end else begin
         r_ped <= w_ped;
         if (emergency) begin
            r_state <= S_STOP;
            r_rem   <= '0;
            r_pre   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (enable) begin
                     r_state <= w_first_state;
                     r_rem   <= w_first_rem;
                     r_pre   <= '0;
                  end
               end
               S_STOP: begin
                  r_state <= S_ALLRED;
                  r_rem   <= CW'(T_ALLRED);
                  r_pre   <= '0;
                  r_ped   <= 1'b0;
               end
               S_ARROW, S_GREEN, S_YELLOW, S_ALLRED: begin
                  if (enable) begin
                     if (w_shorten) begin
                        r_rem <= CW'(T_PED_MIN);
                        r_pre <= '0;
                     end else if (!w_tick) begin
                        r_pre <= r_pre + 1'b1;
                     end else begin
                        r_pre <= '0;
                        if (r_rem > CW'(1)) begin
                           r_rem <= r_rem - 1'b1;
                        end else begin
                           case (r_state)
                              S_ARROW: begin
                                 r_state <= S_GREEN;
                                 r_rem   <= CW'(T_GREEN);
                              end
                              S_GREEN: begin
                                 r_state <= S_YELLOW;
                                 r_rem   <= CW'(T_YELLOW);
                              end
                              S_YELLOW: begin
                                 r_state <= S_ALLRED;
                                 r_rem   <= CW'(T_ALLRED);
                                 r_ped   <= 1'b0;
                              end
                              default: begin
                                 r_state <= w_first_state;
                                 r_rem   <= w_first_rem;
                                 r_dir   <= (r_dir == 3'(N_DIR - 1)) ? 3'd0 : r_dir + 3'd1;
                              end
                           endcase
                        end
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_rem   <= '0;
                  r_pre   <= '0;
               end
            endcase
         end
      end
   end

   assign active_dir = r_dir;
   assign remaining  = r_rem;

   always_comb begin
      states = '0;
      case (r_state)
         S_IDLE:   states[0] = 1'b1;
         S_ARROW:  states[1] = 1'b1;
         S_GREEN:  states[2] = 1'b1;
         S_YELLOW: states[3] = 1'b1;
         S_ALLRED: states[4] = 1'b1;
         S_STOP:   states[5] = 1'b1;
         default:  states    = '0;
      endcase
   end

   // Only the served approach leaves red, and only in ARROW/GREEN/YELLOW.
   generate
      for (genvar gi = 0; gi < N_DIR; gi++) begin : g_lamp
         logic w_served;
         assign w_served   = (r_dir == 3'(gi));
         assign arrow[gi]  = w_served && (r_state == S_ARROW);
         assign green[gi]  = w_served && (r_state == S_GREEN);
         assign yellow[gi] = w_served && (r_state == S_YELLOW);
         assign red[gi]    = !w_served || (r_state == S_IDLE) ||
                             (r_state == S_ALLRED) || (r_state == S_STOP);
      end
   endgenerate

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   logic [6:0] w_val;
   logic [6:0] w_tens;
   logic [6:0] w_units;

   always_comb begin
      w_val = (int'(r_rem) > 99) ? 7'd99 : 7'(r_rem);
   end
   assign w_tens  = w_val / 7'd10;
   assign w_units = w_val % 7'd10;

   always_comb begin
      hex1 = seg7(4'(w_tens));
      hex0 = seg7(4'(w_units));
      if (r_state == S_IDLE) begin
         hex1 = 7'h7F;
         hex0 = 7'h7F;
      end else if (r_state == S_STOP) begin
         hex1 = 7'b0111111;
         hex0 = 7'b0111111;
      end
   end

endmodule

// File: tb/tb_traffic_light_seq.sv
// Bench for traffic_light_seq: directed vector table, random traffic against a
// cycle-budget reference model, and spot checks on two alternate builds.
module tb_traffic_light_seq;

   localparam int D = 4;
   localparam int N_DIR = 2;
   localparam int T_ARROW = 2;
   localparam int T_PED_MIN = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main build
   logic rst, enable, ped_req, emergency;
   logic [1:0] arrow, green, yellow, red;
   logic [2:0] active_dir;
   logic [7:0] remaining;
   logic [5:0] states;
   logic [6:0] hex1, hex0;

   traffic_light_seq #(.TICK_DIV(D), .N_DIR(N_DIR), .CW(8), .T_ARROW(T_ARROW), .T_GREEN(5),
                       .T_YELLOW(2), .T_ALLRED(1), .T_PED_MIN(T_PED_MIN)) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .ped_req(ped_req), .emergency(emergency),
      .arrow(arrow), .green(green), .yellow(yellow), .red(red), .active_dir(active_dir),
      .remaining(remaining), .states(states), .hex1(hex1), .hex0(hex0));

   // build without ARROW
   logic rst_b, en_b;
   logic [1:0] b_arrow, b_green, b_yellow, b_red;
   logic [2:0] b_dir;
   logic [7:0] b_rem;
   logic [5:0] b_states;
   logic [6:0] b_hex1, b_hex0;

   traffic_light_seq #(.TICK_DIV(D), .N_DIR(2), .CW(8), .T_ARROW(0), .T_GREEN(5),
                       .T_YELLOW(2), .T_ALLRED(1), .T_PED_MIN(2)) u_dut_b (
      .clk(clk), .rst(rst_b), .enable(en_b), .ped_req(1'b0), .emergency(1'b0),
      .arrow(b_arrow), .green(b_green), .yellow(b_yellow), .red(b_red), .active_dir(b_dir),
      .remaining(b_rem), .states(b_states), .hex1(b_hex1), .hex0(b_hex0));

   // build with a long GREEN to exercise display saturation
   logic rst_c, en_c;
   logic [1:0] c_arrow, c_green, c_yellow, c_red;
   logic [2:0] c_dir;
   logic [7:0] c_rem;
   logic [5:0] c_states;
   logic [6:0] c_hex1, c_hex0;

   traffic_light_seq #(.TICK_DIV(D), .N_DIR(2), .CW(8), .T_ARROW(2), .T_GREEN(123),
                       .T_YELLOW(2), .T_ALLRED(1), .T_PED_MIN(2)) u_dut_c (
      .clk(clk), .rst(rst_c), .enable(en_c), .ped_req(1'b0), .emergency(1'b0),
      .arrow(c_arrow), .green(c_green), .yellow(c_yellow), .red(c_red), .active_dir(c_dir),
      .remaining(c_rem), .states(c_states), .hex1(c_hex1), .hex0(c_hex0));

   int n_checks = 0;
   int n_fail = 0;

   logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   int tdur [4] = '{2, 5, 2, 1};

   // Reference model: mode -1 idle, 0..3 ARROW/GREEN/YELLOW/ALLRED, 4 stop;
   // m_left counts enabled clock cycles left in the current timed phase.
   int m_mode, m_dir, m_left;
   bit m_ped;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = -1; m_dir = 0; m_left = 0; m_ped = 1'b0;
   endtask

   function automatic int model_rem();
      return (m_mode >= 0 && m_mode <= 3) ? (m_left + D - 1) / D : 0;
   endfunction

   task automatic model_enter(input int p);
      int q;
      q = (p == 0 && T_ARROW == 0) ? 1 : p;
      m_mode = q;
      m_left = tdur[q] * D;
      if (q == 3) m_ped = 1'b0;
   endtask

   task automatic model_step();
      bit ped_eff;
      if (!rst) begin
         model_reset();
         return;
      end
      ped_eff = m_ped | ped_req;
      m_ped = ped_eff;
      if (emergency) begin
         m_mode = 4; m_left = 0;
      end else if (m_mode == 4) begin
         model_enter(3);
      end else if (m_mode == -1) begin
         if (enable) model_enter(0);
      end else if (enable) begin
         if (m_mode == 1 && ped_eff && model_rem() > T_PED_MIN) begin
            m_left = T_PED_MIN * D;
         end else begin
            m_left--;
            if (m_left == 0) begin
               if (m_mode == 3) begin
                  m_dir = (m_dir + 1) % N_DIR;
                  model_enter(0);
               end else begin
                  model_enter(m_mode + 1);
               end
            end
         end
      end
   endtask

   function automatic logic [38:0] model_out();
      logic [5:0] st;
      logic [1:0] ar, gr, ye, rd;
      logic [6:0] h1, h0;
      int r, v;
      r = model_rem();
      st = (m_mode == -1) ? 6'b000001 : (m_mode == 4) ? 6'b100000 : 6'(1 << (m_mode + 1));
      for (int d = 0; d < N_DIR; d++) begin
         ar[d] = (d == m_dir) && (m_mode == 0);
         gr[d] = (d == m_dir) && (m_mode == 1);
         ye[d] = (d == m_dir) && (m_mode == 2);
         rd[d] = !(ar[d] || gr[d] || ye[d]);
      end
      v = (r > 99) ? 99 : r;
      h1 = glyph[v / 10];
      h0 = glyph[v % 10];
      if (m_mode == -1) begin h1 = 7'h7F; h0 = 7'h7F; end
      if (m_mode == 4) begin h1 = 7'h3F; h0 = 7'h3F; end
      return {st, 3'(m_dir), 8'(r), ar, gr, ye, rd, h1, h0};
   endfunction

   function automatic logic [38:0] dut_out();
      return {states, active_dir, remaining, arrow, green, yellow, red, hex1, hex0};
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      cmp("main_outputs", 64'(dut_out()), 64'(model_out()));
   endtask

   typedef struct {
      bit en; bit ped; bit emg; int cyc;
      logic [5:0] st; int dir; int rem;
   } vec_t;

   localparam logic [5:0] SA = 6'b000010, SG = 6'b000100, SY = 6'b001000,
                          SR = 6'b010000, SS = 6'b100000;
   vec_t vt [26];
   int burst;
   int waited;

   initial begin
      vt[0]  = '{1,0,0,1, SA,0,2};  vt[1]  = '{1,0,0,3, SA,0,2};
      vt[2]  = '{1,0,0,1, SA,0,1};  vt[3]  = '{1,0,0,4, SG,0,5};
      vt[4]  = '{1,1,0,1, SG,0,2};  vt[5]  = '{1,0,0,7, SG,0,1};
      vt[6]  = '{1,0,0,1, SY,0,2};  vt[7]  = '{1,0,0,3, SY,0,2};
      vt[8]  = '{1,0,1,1, SS,0,0};  vt[9]  = '{1,0,1,5, SS,0,0};
      vt[10] = '{1,0,0,1, SR,0,1};  vt[11] = '{1,0,0,3, SR,0,1};
      vt[12] = '{1,0,0,1, SA,1,2};  vt[13] = '{1,0,0,8, SG,1,5};
      vt[14] = '{1,0,0,12,SG,1,2};  vt[15] = '{1,0,0,4, SG,1,1};
      vt[16] = '{1,1,0,1, SG,1,1};  vt[17] = '{1,0,0,3, SY,1,2};
      vt[18] = '{1,0,0,8, SR,1,1};  vt[19] = '{1,0,0,4, SA,0,2};
      vt[20] = '{1,0,0,8, SG,0,5};  vt[21] = '{1,0,0,1, SG,0,5};
      vt[22] = '{1,0,0,9, SG,0,3};  vt[23] = '{0,0,0,50,SG,0,3};
      vt[24] = '{1,0,0,9, SG,0,1};  vt[25] = '{1,0,0,1, SY,0,2};

      rst = 1'b0; enable = 1'b0; ped_req = 1'b0; emergency = 1'b0;
      rst_b = 1'b0; en_b = 1'b0; rst_c = 1'b0; en_c = 1'b0;
      model_reset();
      #2;
      cmp("reset_state", 64'(dut_out()), 64'(model_out()));
      cmp("reset_red", 64'(red), 64'(2'b11));
      step(); step();
      rst = 1'b1;
      step();

      // directed sequence: timing, pedestrian, emergency, freeze
      for (int i = 0; i < 26; i++) begin
         enable = vt[i].en; ped_req = vt[i].ped; emergency = vt[i].emg;
         for (int c = 0; c < vt[i].cyc; c++) step();
         cmp($sformatf("vec%0d_state", i), 64'(states), 64'(vt[i].st));
         cmp($sformatf("vec%0d_dir", i), 64'(active_dir), 64'(vt[i].dir));
         cmp($sformatf("vec%0d_rem", i), 64'(remaining), 64'(vt[i].rem));
         if (vt[i].st == SS)
            cmp($sformatf("vec%0d_stop_disp", i), 64'({red, hex1, hex0}), 64'({2'b11, 7'h3F, 7'h3F}));
      end
      ped_req = 1'b0; emergency = 1'b0; enable = 1'b1;

      // asynchronous reset in the middle of GREEN
      waited = 0;
      while (!(states == SG && remaining == 8'd4) && waited < 100) begin
         step();
         waited++;
      end
      cmp("reach_green_budget", 64'(waited < 100), 64'(1));
      rst = 1'b0;
      #1;
      model_reset();
      cmp("async_reset", 64'({states, active_dir, remaining, red, hex1, hex0}),
          64'({6'b000001, 3'd0, 8'd0, 2'b11, 7'h7F, 7'h7F}));
      step();
      rst = 1'b1;
      step();

      // randomized traffic against the model
      burst = 0;
      for (int k = 0; k < 3000; k++) begin
         enable = ($urandom % 10) != 0;
         ped_req = ($urandom % 40) == 0;
         if (burst == 0 && ($urandom % 150) == 0) burst = 3 + int'($urandom % 10);
         emergency = burst > 0;
         if (burst > 0) burst--;
         step();
      end
      enable = 1'b0; ped_req = 1'b0; emergency = 1'b0;

      // alternate builds: no ARROW phase, and long GREEN with display saturation
      rst_b = 1'b1; en_b = 1'b1; rst_c = 1'b1; en_c = 1'b1;
      for (int k = 1; k <= 473; k++) begin
         step();
         if (k == 1) begin
            cmp("noarrow_idle_exit", 64'({b_states, b_rem, b_green}), 64'({SG, 8'd5, 2'b01}));
            cmp("big_arrow", 64'({c_states, c_rem, c_hex1, c_hex0}), 64'({SA, 8'd2, 7'h40, 7'h24}));
         end
         if (k == 33)
            cmp("noarrow_dir1", 64'({b_states, b_dir, b_rem}), 64'({SG, 3'd1, 8'd5}));
         if (k == 9)
            cmp("big_green123", 64'({c_states, c_rem, c_hex1, c_hex0}), 64'({SG, 8'd123, 7'h10, 7'h10}));
         if (k == 105)
            cmp("big_rem99", 64'({c_rem, c_hex1, c_hex0}), 64'({8'd99, 7'h10, 7'h10}));
         if (k == 109)
            cmp("big_rem98", 64'({c_rem, c_hex1, c_hex0}), 64'({8'd98, 7'h10, 7'h00}));
         if (k == 473)
            cmp("big_rem7", 64'({c_states, c_rem, c_hex1, c_hex0}), 64'({SG, 8'd7, 7'h40, 7'h78}));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
